// File: rtl/fb_pixel_source.sv
// rtl/fb_pixel_source.sv - double-buffered RGB332 4x4-cell framebuffer feeding the VGA colour inputs
// Optional back-bank clear engine is built when FB_CLEAR_EN is defined.
module fb_pixel_source #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int CELL_SHIFT = 2,
  parameter int ADDR_W     = 15
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  input  logic       VGA_VS,
  input  logic       wr_en,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic [7:0] wr_color,
  output logic       wr_ready,
  input  logic       swap_req,
  output logic       swap_pending,
  output logic       front_bank,
  input  logic       clear_req,
  input  logic [7:0] clear_color,
  output logic       clear_busy,
  output logic [7:0] R_out,
  output logic [7:0] G_out,
  output logic [7:0] B_out
);

  localparam int          CELLS  = FB_W * FB_H;
  localparam logic [9:0]  ACT_W  = 10'(FB_W << CELL_SHIFT);
  localparam logic [9:0]  ACT_H  = 10'(FB_H << CELL_SHIFT);

  logic [7:0] bank0_mem [CELLS];
  logic [7:0] bank1_mem [CELLS];

  logic [ADDR_W-1:0] rd_cx, rd_cy, rd_addr_d, rd_addr_q;
  logic              rd_valid, vld1_q, vld2_q, sel2_q;
  logic [7:0]        rd0_q, rd1_q, pix;
  logic [7:0]        r_q, g_q, b_q;

  logic              vs_q, vs_fall;
  logic              front_bank_q, front_bank_d;
  logic              swap_pending_q, swap_pending_d;

  logic [ADDR_W-1:0] wr_addr, waddr;
  logic              wr_in_range, we;
  logic [7:0]        wdata;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [7:0]        clr_color;

  // cy*160 + cx built from shifts so no multiplier is inferred
  assign rd_cx     = ADDR_W'(next_x >> CELL_SHIFT);
  assign rd_cy     = ADDR_W'(next_y >> CELL_SHIFT);
  assign rd_addr_d = (rd_cy << 7) + (rd_cy << 5) + rd_cx;
  assign rd_valid  = (next_x < ACT_W) && (next_y < ACT_H);

  assign wr_addr     = (ADDR_W'(wr_y) << 7) + (ADDR_W'(wr_y) << 5) + ADDR_W'(wr_x);
  assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));

`ifdef FB_CLEAR_EN
  typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        clr_color_q, clr_color_d;

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      clr_color_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_color_q <= clr_color_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_color_d = clr_color_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d     = ST_CLEAR;
          cnt_d       = '0;
          clr_color_d = clear_color;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_CELL) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign clr_we     = clear_busy;
  assign clr_addr   = cnt_q;
  assign clr_color  = clr_color_q;
`else
  logic unused_clear;
  assign unused_clear = ^{clear_req, clear_color};
  assign clear_busy   = 1'b0;
  assign clr_we       = 1'b0;
  assign clr_addr     = '0;
  assign clr_color    = '0;
`endif

  assign wr_ready = ~clear_busy;

  always_comb begin
    we    = 1'b0;
    waddr = wr_addr;
    wdata = wr_color;
    if (clr_we) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = clr_color;
    end else if (wr_en && wr_in_range) begin
      we = 1'b1;
    end
  end

  // Writes always target the bank that is not being displayed.
  always_ff @(posedge CLOCK_25) begin
    if (we && front_bank_q)  bank0_mem[waddr] <= wdata;
    if (we && !front_bank_q) bank1_mem[waddr] <= wdata;
    rd0_q <= bank0_mem[rd_addr_q];
    rd1_q <= bank1_mem[rd_addr_q];
  end

  assign vs_fall = vs_q && !VGA_VS;

  always_comb begin
    front_bank_d   = front_bank_q;
    swap_pending_d = swap_pending_q | swap_req;
    if (vs_fall && swap_pending_q && !clear_busy) begin
      front_bank_d   = ~front_bank_q;
      swap_pending_d = 1'b0;
    end
  end

  assign pix = sel2_q ? rd1_q : rd0_q;

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      vs_q           <= 1'b1;
      front_bank_q   <= 1'b0;
      swap_pending_q <= 1'b0;
      rd_addr_q      <= '0;
      vld1_q         <= 1'b0;
      vld2_q         <= 1'b0;
      sel2_q         <= 1'b0;
      r_q            <= '0;
      g_q            <= '0;
      b_q            <= '0;
    end else begin
      vs_q           <= VGA_VS;
      front_bank_q   <= front_bank_d;
      swap_pending_q <= swap_pending_d;
      rd_addr_q      <= rd_valid ? rd_addr_d : '0;
      vld1_q         <= rd_valid;
      vld2_q         <= vld1_q;
      sel2_q         <= front_bank_q;
      if (vld2_q) begin
        r_q <= {pix[7:5], pix[7:5], pix[7:6]};
        g_q <= {pix[4:2], pix[4:2], pix[4:3]};
        b_q <= {pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
      end else begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end
    end
  end

  assign front_bank   = front_bank_q;
  assign swap_pending = swap_pending_q;
  assign R_out        = r_q;
  assign G_out        = g_q;
  assign B_out        = b_q;

endmodule

// File: tb/tb_fb_pixel_source.sv
// tb/tb_fb_pixel_source.sv - self-checking bench for fb_pixel_source
// Clear-engine scenarios are exercised when FB_CLEAR_EN is defined.
module tb_fb_pixel_source;

  localparam int CELLS = 19200;
`ifdef FB_CLEAR_EN
  localparam bit CLEAR_ON = 1'b1;
`else
  localparam bit CLEAR_ON = 1'b0;
`endif

  logic       CLOCK_25 = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] next_x = '0, next_y = '0;
  logic       VGA_VS = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_x = '0;
  logic [6:0] wr_y = '0;
  logic [7:0] wr_color = '0;
  logic       swap_req = 1'b0, clear_req = 1'b0;
  logic [7:0] clear_color = '0;
  logic       wr_ready, swap_pending, front_bank, clear_busy;
  logic [7:0] R_out, G_out, B_out;

  fb_pixel_source dut (
    .CLOCK_25(CLOCK_25), .reset(reset), .next_x(next_x), .next_y(next_y),
    .VGA_VS(VGA_VS), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .wr_ready(wr_ready), .swap_req(swap_req),
    .swap_pending(swap_pending), .front_bank(front_bank),
    .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
    .R_out(R_out), .G_out(G_out), .B_out(B_out)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [23:0] rgb332(input logic [7:0] c);
    int r3, g3, b2;
    r3 = int'(c[7:5]);
    g3 = int'(c[4:2]);
    b2 = int'(c[1:0]);
    rgb332[23:16] = 8'((r3 << 5) | (r3 << 2) | (r3 >> 1));
    rgb332[15:8]  = 8'((g3 << 5) | (g3 << 2) | (g3 >> 1));
    rgb332[7:0]   = 8'(b2 * 85);
  endfunction

  // Behavioural model: cell store per bank with "known" flags since RAM is never reset.
  logic [7:0] m_mem   [2][CELLS];
  bit         m_known [2][CELLS];
  int         m_front = 0, m_pending = 0, m_busy_left = 0;
  logic [7:0] m_clr_color = '0;
  bit         m_vs_prev = 1'b1;
  bit         p1_v = 0, p2_v = 0, p2_k = 1, o_k = 1;
  int         p1_x = 0, p1_y = 0;
  logic [7:0] p2_c = '0;
  logic [7:0] o_r = '0, o_g = '0, o_b = '0;
  int         idx, fr_old;
  bit         busy_old, vs_fall;

  always @(posedge CLOCK_25) begin
    if (reset) begin
      m_front = 0; m_pending = 0; m_busy_left = 0; m_vs_prev = 1'b1;
      p1_v = 0; p2_v = 0; o_k = 1; o_r = 0; o_g = 0; o_b = 0;
    end else begin
      busy_old = (m_busy_left > 0);
      fr_old   = m_front;
      if (p2_v) begin
        o_k = p2_k;
        {o_r, o_g, o_b} = rgb332(p2_c);
      end else begin
        o_k = 1; o_r = 0; o_g = 0; o_b = 0;
      end
      p2_v = p1_v;
      if (p1_v) begin
        idx  = (p1_y / 4) * 160 + (p1_x / 4);
        p2_k = m_known[fr_old][idx];
        p2_c = m_mem[fr_old][idx];
      end
      p1_v = (next_x < 640) && (next_y < 480);
      p1_x = int'(next_x);
      p1_y = int'(next_y);
      if (wr_en && !busy_old && wr_x < 160 && wr_y < 120) begin
        idx = int'(wr_y) * 160 + int'(wr_x);
        m_mem[1 - fr_old][idx]   = wr_color;
        m_known[1 - fr_old][idx] = 1'b1;
      end
      if (busy_old) begin
        m_busy_left--;
        if (m_busy_left == 0)
          for (int i = 0; i < CELLS; i++) begin
            m_mem[1 - fr_old][i]   = m_clr_color;
            m_known[1 - fr_old][i] = 1'b1;
          end
      end else if (clear_req && CLEAR_ON) begin
        m_busy_left = CELLS;
        m_clr_color = clear_color;
      end
      vs_fall   = m_vs_prev && !VGA_VS;
      m_vs_prev = VGA_VS;
      if (vs_fall && m_pending != 0 && !busy_old) begin
        m_front   = 1 - fr_old;
        m_pending = 0;
      end else if (swap_req) begin
        m_pending = 1;
      end
    end
  end

  always @(negedge CLOCK_25) begin
    if (!reset) begin
      if (o_k) begin
        chk("R_out", int'(R_out), int'(o_r));
        chk("G_out", int'(G_out), int'(o_g));
        chk("B_out", int'(B_out), int'(o_b));
      end
      chk("front_bank", int'(front_bank), m_front);
      chk("swap_pending", int'(swap_pending), m_pending);
      chk("clear_busy", int'(clear_busy), int'(m_busy_left > 0));
      chk("wr_ready", int'(wr_ready), int'(m_busy_left == 0));
    end
  end

  task automatic write_cell(input int x, input int y, input logic [7:0] c);
    wr_en = 1'b1; wr_x = 8'(x); wr_y = 7'(y); wr_color = c;
    @(negedge CLOCK_25);
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(negedge CLOCK_25);
    swap_req = 1'b0;
  endtask

  task automatic vsync();
    VGA_VS = 1'b0;
    repeat (4) @(negedge CLOCK_25);
    VGA_VS = 1'b1;
    repeat (2) @(negedge CLOCK_25);
  endtask

  task automatic show(input int x, input int y);
    next_x = 10'(x); next_y = 10'(y);
    repeat (3) @(negedge CLOCK_25);
  endtask

  task automatic scan_row(input int y);
    for (int x = 0; x < 640; x += 4) begin
      next_x = 10'(x); next_y = 10'(y);
      @(negedge CLOCK_25);
    end
  endtask

  int busy_cnt;

  initial begin
    repeat (3) @(negedge CLOCK_25);
    chk("reset front_bank", int'(front_bank), 0);
    chk("reset swap_pending", int'(swap_pending), 0);
    chk("reset clear_busy", int'(clear_busy), 0);
    chk("reset wr_ready", int'(wr_ready), 1);
    chk("reset R_out", int'(R_out), 0);
    reset = 1'b0;
    @(negedge CLOCK_25);

    // Red cell at (0,0) becomes visible after swap + vsync.
    write_cell(0, 0, 8'hE0);
    write_cell(159, 119, 8'h40);
    pulse_swap();
    chk("pending after req", int'(swap_pending), 1);
    vsync();
    chk("front after swap1", int'(front_bank), 1);
    chk("pending after swap1", int'(swap_pending), 0);
    for (int x = 0; x < 4; x++) begin
      next_x = 10'(x); next_y = 10'd0;
      @(negedge CLOCK_25);
    end
    show(3, 0);
    chk("cell00 R", int'(R_out), 8'hFF);
    chk("cell00 G", int'(G_out), 0);
    chk("cell00 B", int'(B_out), 0);

    // Back-bank write stays hidden until the next swap.
    write_cell(159, 119, 8'h03);
    show(639, 479);
    chk("corner old R", int'(R_out), 8'h49);
    chk("corner old B", int'(B_out), 0);
    pulse_swap();
    vsync();
    show(639, 479);
    chk("corner new B", int'(B_out), 8'hFF);
    chk("corner new R", int'(R_out), 0);

    // Blanking area and out-of-range writes.
    show(700, 100);
    chk("blank R", int'(R_out), 0);
    chk("blank G", int'(G_out), 0);
    chk("blank B", int'(B_out), 0);
    write_cell(0, 1, 8'h12);
    write_cell(40, 6, 8'h34);
    write_cell(160, 0, 8'hFF);
    write_cell(200, 5, 8'hFF);
    write_cell(0, 120, 8'hFF);
    write_cell(255, 127, 8'hFF);
    pulse_swap();
    vsync();
    scan_row(0);
    scan_row(4);
    scan_row(24);
    show(0, 4);
    chk("cell01 R", int'(R_out), 0);
    chk("cell01 G", int'(G_out), 8'h92);
    chk("cell01 B", int'(B_out), 8'hAA);

    // Double swap request toggles only once.
    pulse_swap();
    repeat (2) @(negedge CLOCK_25);
    pulse_swap();
    vsync();
    chk("front after double req", int'(front_bank), 0);
    chk("pending after double req", int'(swap_pending), 0);
    vsync();
    chk("front after idle vsync", int'(front_bank), 0);

`ifdef FB_CLEAR_EN
    clear_color = 8'h1C;
    clear_req = 1'b1;
    swap_req  = 1'b1;
    @(negedge CLOCK_25);
    clear_req = 1'b0;
    swap_req  = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20000 && clear_busy; i++) begin
      busy_cnt++;
      VGA_VS = !(i >= 100 && i < 104);
      @(negedge CLOCK_25);
    end
    VGA_VS = 1'b1;
    chk("clear_busy cycles", busy_cnt, CELLS);
    chk("front held during clear", int'(front_bank), 0);
    chk("pending held during clear", int'(swap_pending), 1);
    @(negedge CLOCK_25);
    vsync();
    chk("front after clear swap", int'(front_bank), 1);
    for (int y = 0; y < 480; y += 4) scan_row(y);
    show(320, 240);
    chk("cleared G", int'(G_out), 8'hFF);
    chk("cleared R", int'(R_out), 0);
    chk("cleared B", int'(B_out), 0);
    clear_color = 8'hE3;
    clear_req = 1'b1;
    @(negedge CLOCK_25);
    clear_req = 1'b0;
    repeat (50) @(negedge CLOCK_25);
    chk("busy before abort", int'(clear_busy), 1);
`else
    clear_color = 8'h1C;
    clear_req = 1'b1;
    @(negedge CLOCK_25);
    clear_req = 1'b0;
    repeat (3) @(negedge CLOCK_25);
    chk("no-clear busy", int'(clear_busy), 0);
    chk("no-clear ready", int'(wr_ready), 1);
    pulse_swap();
    vsync();
    chk("front before reset", int'(front_bank), 1);
`endif

    // Asynchronous reset mid-operation.
    show(0, 0);
    reset = 1'b1;
    #1;
    chk("abort clear_busy", int'(clear_busy), 0);
    chk("abort wr_ready", int'(wr_ready), 1);
    chk("abort front_bank", int'(front_bank), 0);
    chk("abort R_out", int'(R_out), 0);
    chk("abort G_out", int'(G_out), 0);
    chk("abort B_out", int'(B_out), 0);
    repeat (2) @(negedge CLOCK_25);
    reset = 1'b0;
    repeat (10) @(negedge CLOCK_25);
    chk("post reset swap_pending", int'(swap_pending), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
